// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared period counter and per-channel shadow duty registers.
// Define PWM_CENTER_ALIGN_EN for an up/down (centre-aligned) counter; the default is edge-aligned.
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PERIOD   = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      duty_wr,
  output logic [CHANNELS-1:0]       pulse,
  output logic                      period_end,
  output logic [WIDTH-1:0]          count
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]          count_q, count_d;
  logic [CHANNELS*WIDTH-1:0] pend_q, pend_d;
  logic [CHANNELS*WIDTH-1:0] act_q, act_d;
  logic                      flag_q, flag_d;
  logic [CHANNELS-1:0]       pulse_q, pulse_d;
  logic                      pe_q, pe_d;
  logic                      boundary;
  logic                      load;

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
  localparam bit SINGLE_STEP = (PERIOD == 1);

  dir_t dir_q, dir_d;

  // With PERIOD=1 the down phase is empty, so the top cycle is also the boundary.
  always_comb begin
    boundary = (count_q == ONE) && ((dir_q == DIR_DOWN) || SINGLE_STEP);
    count_d  = count_q;
    dir_d    = dir_q;
    if (!enable || boundary) begin
      count_d = '0;
      dir_d   = DIR_UP;
    end else if (dir_q == DIR_UP && count_q == TOP) begin
      count_d = count_q - ONE;
      dir_d   = DIR_DOWN;
    end else if (dir_q == DIR_UP) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dir_q <= DIR_UP;
    else     dir_q <= dir_d;
  end
`else
  always_comb begin
    boundary = (count_q == TOP);
    count_d  = count_q + ONE;
    if (!enable || boundary) count_d = '0;
  end
`endif

  // Shadow path: a write coinciding with a load bypasses pending and lands in active directly.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    flag_d = flag_q;
    load   = !enable || boundary;
    if (duty_wr) pend_d = duty;
    if (load) begin
      flag_d = 1'b0;
      if (duty_wr)     act_d = duty;
      else if (flag_q) act_d = pend_q;
    end else if (duty_wr) begin
      flag_d = 1'b1;
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pulse_d[i] = enable && (count_q < act_q[i*WIDTH +: WIDTH]);
    end
    pe_d = enable && boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      flag_q  <= 1'b0;
      pulse_q <= '0;
      pe_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
      pe_q    <= pe_d;
    end
  end

  assign pulse      = pulse_q;
  assign period_end = pe_q;
  assign count      = count_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: a PERIOD=9 instance for timing/shadow behaviour and a PERIOD=255 instance for the full-width boundary.
module tb_pwm_multi;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int P  = 9;
`ifdef PWM_CENTER_ALIGN_EN
  localparam int PLEN = 2 * P;
`else
  localparam int PLEN = P + 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, enable;
  logic [CH*W-1:0] duty, duty_m;
  logic            duty_wr, duty_wr_m;
  logic [CH-1:0]   pulse, pulse_m;
  logic            period_end, pe_m;
  logic [W-1:0]    count, count_m;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PERIOD(P)) dut (
    .clk(clk), .rst(rst), .enable(enable), .duty(duty), .duty_wr(duty_wr),
    .pulse(pulse), .period_end(period_end), .count(count)
  );

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PERIOD(255)) dut_max (
    .clk(clk), .rst(rst), .enable(enable), .duty(duty_m), .duty_wr(duty_wr_m),
    .pulse(pulse_m), .period_end(pe_m), .count(count_m)
  );

  // scoreboard
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Counter value shown t cycles after a period start.
  function automatic int cnt_at(input int t);
    int tm;
    tm = t % PLEN;
`ifdef PWM_CENTER_ALIGN_EN
    return (tm <= P) ? tm : 2 * P - tm;
`else
    return tm;
`endif
  endfunction

  function automatic logic [CH-1:0] exp_pulse(input int c, input logic [CH*W-1:0] d);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (c < int'(d[i*W +: W]));
    return r;
  endfunction

  function automatic logic [CH*W-1:0] pk(input int d3, input int d2, input int d1, input int d0);
    return {W'(d3), W'(d2), W'(d1), W'(d0)};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_duty(input logic [CH*W-1:0] d);
    duty    = d;
    duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
  endtask

  task automatic wait_pe(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (period_end !== 1'b1 && n < budget);
    check("pe_wait", period_end, 1);
  endtask

  // Runs one full period starting right after a period_end cycle (or an enable rise).
  task automatic run_period(input logic [CH*W-1:0] d, input string tag);
    for (int t = 1; t <= PLEN; t++) exp_q.push_back(exp_pulse(cnt_at(t - 1), d));
    for (int t = 1; t <= PLEN; t++) begin
      tick();
      check({tag, "_pulse"}, pulse, exp_q.pop_front());
      check({tag, "_cnt"}, count, cnt_at(t));
      check({tag, "_pe"}, period_end, (t == PLEN));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h[CH];
    int n;
    rst = 1'b1; enable = 1'b0;
    duty = '0; duty_wr = 1'b0; duty_m = '0; duty_wr_m = 1'b0;

    // reset and idle run
    repeat (3) tick();
    check("rst_count", count, 0);
    check("rst_pulse", pulse, 0);
    check("rst_pe", period_end, 0);
    rst = 1'b0; enable = 1'b1;
    for (int j = 1; j <= 2 * PLEN; j++) begin
      tick();
      check("idle_cnt", count, cnt_at(j));
      check("idle_pulse", pulse, 0);
      check("idle_pe", period_end, (j % PLEN == 0));
    end

    // duty ratios 0,3,5,10
    write_duty(pk(10, 5, 3, 0));
    wait_pe(PLEN + 2);
    repeat (3) run_period(pk(10, 5, 3, 0), "ratio");

`ifdef PWM_CENTER_ALIGN_EN
    // mid-period shadow load; ch0=4 gives 7 highs centred on count 0
    repeat (5) tick();
    write_duty(pk(10, 9, 0, 4));
    for (int j = 0; j < 20 && period_end !== 1'b1; j++) begin
      check("c_old_ch0", pulse[0], 0);
      tick();
    end
    check("c_boundary", period_end, 1);
    check("c_boundary_cnt", count, 0);
    run_period(pk(10, 9, 0, 4), "c_shadow");
    h[0] = 0;
    for (int t = 1; t <= PLEN; t++) begin
      tick();
      h[0] += int'(pulse[0]);
    end
    check("c_high_ch0", h[0], 7);
    check("c_pe_end", period_end, 1);
`else
    // shadow timing: writes at count 4 and 6, last one wins
    repeat (4) tick();
    check("t3_at4", count, 4);
    duty = pk(10, 5, 3, 2); duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
    check("t3_old_a", pulse[0], 0);
    tick();
    check("t3_at6", count, 6);
    duty = pk(10, 5, 3, 7); duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
    check("t3_old_b", pulse[0], 0);
    tick();
    check("t3_old_c", pulse[0], 0);
    tick();
    check("t3_old_d", pulse[0], 0);
    tick();
    check("t3_old_e", pulse[0], 0);
    check("t3_wrap_pe", period_end, 1);
    run_period(pk(10, 5, 3, 7), "lastwins");

    // write exactly at count==PERIOD applies in the very next period
    repeat (9) tick();
    check("t3_at9", count, 9);
    write_duty(pk(10, 5, 3, 2));
    check("t3_top_pe", period_end, 1);
    run_period(pk(10, 5, 3, 2), "wr_at_top");
    run_period(pk(10, 5, 3, 2), "wr_at_top2");

    // mid-period reset clears active duty
    write_duty(pk(5, 5, 5, 5));
    wait_pe(PLEN + 2);
    repeat (5) tick();
    check("t4_at5", count, 5);
    rst = 1'b1;
    tick();
    check("mrst_count", count, 0);
    check("mrst_pulse", pulse, 0);
    check("mrst_pe", period_end, 0);
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      check("mrst_cnt", count, cnt_at(j));
      check("mrst_hold0", pulse, 0);
    end

    // enable drop at count 3 for 4 cycles, then clean restart
    write_duty(pk(5, 5, 5, 5));
    wait_pe(PLEN + 2);
    run_period(pk(5, 5, 5, 5), "en_pre");
    repeat (3) tick();
    check("en_at3", count, 3);
    enable = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("dis_cnt", count, 0);
      check("dis_pulse", pulse, 0);
      check("dis_pe", period_end, 0);
    end
    enable = 1'b1;
    run_period(pk(5, 5, 5, 5), "en_restart");

    // full-width boundary on the PERIOD=255 instance
    check("max_idle", pulse_m, 0);
    duty_m = pk(255, 0, 255, 0); duty_wr_m = 1'b1;
    tick();
    duty_wr_m = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (pe_m !== 1'b1 && n < 300);
    check("max_pe_wait", pe_m, 1);
    for (int i = 0; i < CH; i++) h[i] = 0;
    for (int t = 1; t <= 256; t++) begin
      tick();
      for (int i = 0; i < CH; i++) h[i] += int'(pulse_m[i]);
      if (t == 255) check("max_t255", pulse_m, 4'b1010);
      if (t == 256) begin
        check("max_t256", pulse_m, 4'b0000);
        check("max_pe", pe_m, 1);
        check("max_cnt0", count_m, 0);
      end
    end
    check("max_high_ch1", h[1], 255);
    check("max_high_ch3", h[3], 255);
    check("max_high_ch0", h[0], 0);
    check("max_high_ch2", h[2], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
